// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a valid/ready result handshake.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      md_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result,
  output logic            md_zero
);

  localparam int unsigned     CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_next_state;
  logic [XLEN-1:0] r_hi, r_lo, r_m, r_result;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;

  logic            w_accept, w_sa, w_sb, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic [XLEN:0]   w_msum, w_shift, w_trial;
  logic [XLEN-1:0] w_hi_n, w_lo_n, w_final;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept = in_valid && in_ready;

  // md_op[2] selects divide; md_op[0] marks the unsigned divide variants
  assign w_sa    = (md_op[2] ? ~md_op[0] : (md_op[1:0] != 2'b11)) & op_a[XLEN-1];
  assign w_sb    = (md_op[2] ? ~md_op[0] : ~md_op[1]) & op_b[XLEN-1];
  assign w_mag_a = w_sa ? -op_a : op_a;
  assign w_mag_b = w_sb ? -op_b : op_b;
  assign w_div0  = md_op[2] && (op_b == '0);
  assign w_ovf   = md_op[2] && !md_op[0] && (op_a == SMIN) && (op_b == '1);

  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_m};

  always_comb begin
    w_hi_n  = '0;
    w_lo_n  = '0;
    w_final = '0;
    if (r_op[2]) begin
      if (!w_trial[XLEN]) begin
        w_hi_n = w_trial[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_n = w_shift[XLEN-1:0];
        w_lo_n = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_n = w_msum[XLEN:1];
      w_lo_n = {w_msum[0], r_lo[XLEN-1:1]};
    end
    w_prod = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    if (r_op[2])
      w_final = r_op[1] ? (r_neg ? -w_hi_n : w_hi_n) : (r_neg ? -w_lo_n : w_lo_n);
    else
      w_final = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next_state = (w_div0 || w_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == LAST) w_next_state = S_DONE;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= md_op;
          r_cnt <= '0;
          r_hi  <= '0;
          // Multiply: r_m = multiplicand, r_lo = multiplier; divide: r_m = divisor, r_lo = dividend
          r_m   <= md_op[2] ? w_mag_b : w_mag_a;
          r_lo  <= md_op[2] ? w_mag_a : w_mag_b;
          r_neg <= (md_op[2] && md_op[1]) ? w_sa : (w_sa ^ w_sb);
          if (w_div0)     r_result <= md_op[1] ? op_a : '1;
          else if (w_ovf) r_result <= md_op[1] ? '0 : op_a;
        end
        S_CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign md_result = r_result;
  assign md_zero   = (r_result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit at XLEN=32, with latency,
// backpressure, operand-isolation and reset-abort checks.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  md_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] md_result;
  logic        md_zero;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .md_op     (md_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .md_result (md_result),
    .md_zero   (md_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latency counts rising edges starting with the accept edge itself.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    exp_t e;
    int   lat;
    sb.push_back('{res: exp, lat: exp_lat});
    @(negedge clk);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    md_op     = op;
    op_a      = a;
    op_b      = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    md_op    = 3'($urandom);
    op_b     = $urandom;
    op_a     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      op_a = $urandom;
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_valid"},   {31'b0, out_valid}, 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_result"},  md_result, e.res);
    check({tag, "_zero"},    {31'b0, md_zero}, {31'b0, e.res == 32'd0});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"},  {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_result"}, md_result, e.res);
      check({tag, "_hold_ready"},  {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, "_hs_ready"}, {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_post_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] wide;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    md_op     = '0;
    #12;
    check("rst_in_ready",  {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    md_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("remu",    3'b111, 32'd10,       32'd5,        32'd0,        33, 0);
    run_op("divu_z",  3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op("rem_z",   3'b110, 32'd5,        32'd0,        32'd5,        1,  0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    run_op("mul_bp",  3'b000, 32'd1234,     32'd5678,     32'd7006652,  33, 5);

    for (int k = 0; k < 3; k++) begin
      ra   = $urandom;
      rb   = $urandom_range(32'hFFFF, 1);
      wide = {32'b0, ra} * {32'b0, rb};
      run_op("rnd_mulhu", 3'b011, ra, rb, wide[63:32], 33, 0);
      run_op("rnd_divu",  3'b101, ra, rb, ra / rb, 33, 0);
      run_op("rnd_remu",  3'b111, ra, rb, ra % rb, 33, 0);
    end

    @(negedge clk);
    in_valid = 1'b1;
    md_op    = 3'b100;
    op_a     = 32'd1000;
    op_b     = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready",  {31'b0, in_ready}, 32'd0);
    check("abort_result",    md_result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
